// File: rtl/seven_seg_driver.sv
// seven_seg_driver: time-multiplexed 4-digit hex seven-segment driver with registered, active-low outputs.
// Define SSD_GHOST_BLANK_EN to turn anodes off for the first BLANK_CYCLES cycles of every slot.
module seven_seg_driver #(
  parameter int REFRESH_DIV  = 4096,
  parameter int BLANK_CYCLES = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       digit0_en_i,
  input  logic       digit1_en_i,
  input  logic       digit2_en_i,
  input  logic       digit3_en_i,
  input  logic [3:0] digit0_i,
  input  logic [3:0] digit1_i,
  input  logic [3:0] digit2_i,
  input  logic [3:0] digit3_i,
  input  logic [3:0] dp_i,
  output logic [3:0] anode_o,
  output logic [6:0] segments_o,
  output logic       dp_o
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
`ifdef SSD_GHOST_BLANK_EN
  localparam logic GHOST = 1'b1;
`else
  localparam logic GHOST = 1'b0;
`endif
  // Indexed by hex value, {g,f,e,d,c,b,a}, active-low.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d, nxt;
  logic          en_q, en_d;
  logic [3:0]    val_q, val_d;
  logic          dpr_q, dpr_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dpo_q, dpo_d;
  logic          tick, blank;
  logic [3:0]    en_v;
  // Outputs are computed from next-state values so the new slot appears right after the tick edge.
  always_comb begin
    tick    = cnt_q == LAST;
    nxt     = slot_q + 2'd1;
    en_v    = {digit3_en_i, digit2_en_i, digit1_en_i, digit0_en_i};
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    slot_d  = tick ? nxt : slot_q;
    en_d    = tick ? en_v[nxt] : en_q;
    val_d   = !tick ? val_q : nxt == 2'd0 ? digit0_i : nxt == 2'd1 ? digit1_i :
              nxt == 2'd2 ? digit2_i : digit3_i;
    dpr_d   = tick ? dp_i[nxt] : dpr_q;
    blank   = GHOST && (cnt_d < BLANK);
    anode_d = (en_d && !blank) ? ~(4'b0001 << slot_d) : 4'hF;
    seg_d   = en_d ? SEG_LUT[val_d] : 7'h7F;
    dpo_d   = ~(en_d & dpr_d);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      slot_q  <= 2'd3;
      en_q    <= 1'b0;
      val_q   <= 4'h0;
      dpr_q   <= 1'b0;
      anode_q <= 4'hF;
      seg_q   <= 7'h7F;
      dpo_q   <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      en_q    <= en_d;
      val_q   <= val_d;
      dpr_q   <= dpr_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
    end
  end
  assign anode_o    = anode_q;
  assign segments_o = seg_q;
  assign dp_o       = dpo_q;
endmodule

// File: doc/seven_seg_driver.md
SEVEN_SEG_DRIVER -- requirements
Module: seven_seg_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 4096: clock cycles per digit slot; legal range 2..65536.
REQ-002 Parameter BLANK_CYCLES, default 256: anode-off cycles at the start of each slot; legal range 1..REFRESH_DIV-1.
REQ-003 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous reset, active-high.
REQ-005 digitN_en_i  input  1  (N=0..3) digit N shown when 1, blanked when 0.
REQ-006 digitN_i  input  4  (N=0..3) hex value of digit N.
REQ-007 dp_i  input  4  decimal point request; bit N maps to digit N, 1 means lit.
REQ-008 anode_o  output  4  active-low digit select; bit N drives digit N.
REQ-009 segments_o  output  7  active-low cathodes, bit order {g,f,e,d,c,b,a}.
REQ-010 dp_o  output  1  active-low decimal point cathode.

Function
REQ-011 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; tick asserts in the cycle the counter equals REFRESH_DIV-1.
REQ-012 The slot index SHALL advance 0->1->2->3->0 on each tick, wrapping from 3 to 0.
REQ-013 On tick, the shadow register SHALL capture digitK_en_i, digitK_i and dp_i[K], where K is the next index. Inputs SHALL have no effect mid-slot.
REQ-014 Outputs SHALL be registered and SHALL reflect the new slot in the first cycle after the tick edge (latency 1 cycle from capture).
REQ-015 With shadow en=1, anode_o SHALL have only bit K low, segments_o = decode(value) and dp_o = ~dp.
REQ-016 With shadow en=0, anode_o SHALL be 4'b1111, segments_o 7'h7F and dp_o 1, regardless of dp.
REQ-017 The decode SHALL be full hex: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-018 At most one anode_o bit SHALL be low in any cycle.
REQ-019 An input change coinciding with the tick cycle SHALL be captured.

Reset
REQ-020 While rst_i=1 at a clock edge, the block SHALL load: refresh counter 0, slot index 3, shadow en 0, anode_o 4'b1111, segments_o 7'h7F, dp_o 1.
REQ-021 After reset releases, the first tick SHALL select digit 0, so outputs stay blank for REFRESH_DIV cycles after release.
REQ-022 Reset asserted mid-slot or in a tick cycle SHALL take priority over the tick. The next cycle SHALL show reset values.

Configuration
REQ-023 Macro SSD_GHOST_BLANK_EN defined: anode_o SHALL be forced to 4'b1111 while the refresh counter is below BLANK_CYCLES in every slot. segments_o and dp_o still follow REQ-015/016.
REQ-024 SSD_GHOST_BLANK_EN undefined: no anode-off interval; BLANK_CYCLES SHALL be ignored and anodes SHALL follow REQ-015/016 for the full slot.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1)
REQ-025 Reset released, all en=1, values 1,2,3,4 -> 4 blank cycles, then anode_o 1110 with segments_o 1111001, then 1101 with 0100100, 1011 with 0110000, 0111 with 0011001, repeating every 16 cycles.
REQ-026 digit2_en_i=0, others 1 -> during slot 2 anode_o=1111 and segments_o=7F; slots 0, 1 and 3 unaffected.
REQ-027 digit0_i changes 5->F two cycles into slot 0 -> 0010010 persists to the end of the slot; 0001110 appears on the next visit to slot 0.
REQ-028 dp_i=0100, all en=1 -> dp_o=0 only during slot 2; with digit2_en_i=0, dp_o stays 1.
REQ-029 SSD_GHOST_BLANK_EN defined -> first cycle of each slot anode_o=1111, then the selected anode goes low for 3 cycles; undefined -> the selected anode is low for all 4 cycles.
REQ-030 rst_i pulsed for 1 cycle during slot 2 -> next cycle shows reset values; digit 0 is shown 4 cycles later.
